// File: rtl/card_grid_renderer.sv
// card_grid_renderer
//   Draws a ROWS x COLS grid of memory-match cards from the VGA scan position.
//   The block keeps each card's face-up and matched state. It also runs a
//   frame-paced flip animation: the card squeezes horizontally to a sliver,
//   swaps face, then widens again. A shared external card ROM supplies the
//   pixels. The ROM is addressed from pipeline stage 1, and its combinational
//   output is registered into rgb in stage 2.
//
//   Optional build macro: CURSOR_EN
//     Adds cursor_idx. The selected card gets a 2-pixel border of colour 3'b110.
//
// Ports
//   clk, reset          pixel clock, asynchronous active-high reset
//   HCount, VCount      scan position
//   frame_tick          one-cycle pulse per frame; paces the flip animation
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_op, cmd_idx     00 show, 01 hide, 10 mark matched, 11 clear board
//   busy                flip animation in progress
//   rom_card/face/x/y   card ROM address (registered, stage 1)
//   rom_pix             ROM pixel, combinational from rom_*
//   cursor_idx          cursor card (CURSOR_EN builds only)
//   cardon, rgb         registered pixel outputs (stage 2)
module card_grid_renderer #(
  parameter int unsigned COLS        = 4,
  parameter int unsigned ROWS        = 4,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned CARD_W      = 83,
  parameter int unsigned CARD_H      = 83,
  parameter int unsigned PITCH_X     = 100,
  parameter int unsigned PITCH_Y     = 100,
  parameter int unsigned ORG_X       = 130,
  parameter int unsigned ORG_Y       = 70,
  parameter int unsigned FLIP_FRAMES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       HCount,
  input  logic [9:0]       VCount,
  input  logic             frame_tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  output logic             busy,
  output logic [IDX_W-1:0] rom_card,
  output logic             rom_face,
  output logic [6:0]       rom_x,
  output logic [6:0]       rom_y,
  input  logic [2:0]       rom_pix,
`ifdef CURSOR_EN
  input  logic [IDX_W-1:0] cursor_idx,
`endif
  output logic             cardon,
  output logic [2:0]       rgb
);

  localparam int unsigned NCARDS = COLS * ROWS;
  // The state vectors are sized to the full index space, so cmd_idx can
  // index them directly. Slots at or above NCARDS are never written.
  localparam int unsigned NSLOT  = 1 << IDX_W;
  localparam int unsigned STEP   = CARD_W / (2 * FLIP_FRAMES);
  localparam int unsigned NW     = $clog2(FLIP_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHRINK,
    S_GROW
  } state_t;

  state_t             state_q, state_d;
  logic [NW-1:0]      n_q, n_d;
  logic [IDX_W-1:0]   anim_idx_q, anim_idx_d;
  logic [NSLOT-1:0]   face_q, face_d;
  logic [NSLOT-1:0]   matched_q, matched_d;

  logic               idx_ok;
  logic               accept;

  // ---------------------------------------------------------------------------
  // Command / animation FSM
  // ---------------------------------------------------------------------------
  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = ~busy;
  assign accept    = cmd_valid && (state_q == S_IDLE);
  assign idx_ok    = (32'(cmd_idx) < NCARDS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      anim_idx_q <= '0;
      face_q     <= '0;
      matched_q  <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      anim_idx_q <= anim_idx_d;
      face_q     <= face_d;
      matched_q  <= matched_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    anim_idx_d = anim_idx_q;
    face_d     = face_q;
    matched_d  = matched_q;
    case (state_q)
      S_IDLE: begin
        // Ticks are not looked at while idle. A tick that arrives in the
        // same cycle as acceptance is therefore dropped.
        if (accept) begin
          case (cmd_op)
            2'b00, 2'b01: begin
              // Animate only a real change: an unmatched card whose current
              // face differs from the requested one.
              if (idx_ok && !matched_q[cmd_idx] &&
                  (face_q[cmd_idx] == cmd_op[0])) begin
                anim_idx_d = cmd_idx;
                n_d        = '0;
                state_d    = S_SHRINK;
              end
            end
            2'b10: begin
              if (idx_ok) matched_d[cmd_idx] = 1'b1;
            end
            default: begin
              face_d    = '0;
              matched_d = '0;
            end
          endcase
        end
      end
      S_SHRINK: begin
        if (frame_tick) begin
          n_d = n_q + NW'(1);
          // The face swaps only here, when the card is at its narrowest.
          if (n_q == NW'(FLIP_FRAMES - 1)) begin
            face_d[anim_idx_q] = ~face_q[anim_idx_q];
            state_d            = S_GROW;
          end
        end
      end
      S_GROW: begin
        if (frame_tick) begin
          n_d = n_q - NW'(1);
          if (n_q == NW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline, stage 1: locate the card and local coordinates
  // ---------------------------------------------------------------------------
  int unsigned      hx, vy;
  int unsigned      col, row, lx, ly, m, card;
  logic             col_hit, row_hit;
  logic [IDX_W-1:0] card_idx;
  logic             clip;
  logic             hit_d;

  always_comb begin
    hx      = 32'(HCount);
    vy      = 32'(VCount);
    col_hit = 1'b0;
    row_hit = 1'b0;
    col     = 0;
    row     = 0;
    lx      = 0;
    ly      = 0;
    // Each column and row gets its own range comparator. The pitch is at
    // least the card size, so at most one column and one row can match.
    for (int unsigned c = 0; c < COLS; c++) begin
      if (hx >= ORG_X + c * PITCH_X && hx < ORG_X + c * PITCH_X + CARD_W) begin
        col_hit = 1'b1;
        col     = c;
        lx      = hx - (ORG_X + c * PITCH_X);
      end
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (vy >= ORG_Y + r * PITCH_Y && vy < ORG_Y + r * PITCH_Y + CARD_H) begin
        row_hit = 1'b1;
        row     = r;
        ly      = vy - (ORG_Y + r * PITCH_Y);
      end
    end
    card     = row * COLS + col;
    card_idx = IDX_W'(card);
    m        = 32'(n_q) * STEP;
    // Squeeze: the animated card keeps only its centre columns [m, CARD_W-1-m].
    // Writing the right-hand test as lx + m avoids an unsigned underflow.
    clip     = busy && (card_idx == anim_idx_q) &&
               ((lx < m) || (lx + m > CARD_W - 1));
    hit_d    = col_hit && row_hit && !matched_q[card_idx] && !clip;
  end

`ifdef CURSOR_EN
  logic border_d, border1_q;
  assign border_d = hit_d && (card_idx == cursor_idx) &&
                    ((lx < 2) || (lx > CARD_W - 3) ||
                     (ly < 2) || (ly > CARD_H - 3));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) border1_q <= 1'b0;
    else       border1_q <= border_d;
  end
`endif

  logic             hit1_q;
  logic [IDX_W-1:0] rom_card_q;
  logic             rom_face_q;
  logic [6:0]       rom_x_q, rom_y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit1_q     <= 1'b0;
      rom_card_q <= '0;
      rom_face_q <= 1'b0;
      rom_x_q    <= '0;
      rom_y_q    <= '0;
    end else begin
      hit1_q <= hit_d;
      if (hit_d) begin
        rom_card_q <= card_idx;
        rom_face_q <= face_q[card_idx];
        rom_x_q    <= 7'(lx);
        rom_y_q    <= 7'(ly);
      end else begin
        rom_card_q <= '0;
        rom_face_q <= 1'b0;
        rom_x_q    <= '0;
        rom_y_q    <= '0;
      end
    end
  end

  assign rom_card = rom_card_q;
  assign rom_face = rom_face_q;
  assign rom_x    = rom_x_q;
  assign rom_y    = rom_y_q;

  // ---------------------------------------------------------------------------
  // Pixel pipeline, stage 2: register the colour
  // ---------------------------------------------------------------------------
  logic       cardon_q;
  logic [2:0] rgb_q;
  logic [2:0] pix_sel;

`ifdef CURSOR_EN
  assign pix_sel = border1_q ? 3'b110 : rom_pix;
`else
  assign pix_sel = rom_pix;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cardon_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      cardon_q <= hit1_q;
      rgb_q    <= hit1_q ? pix_sel : 3'b000;
    end
  end

  assign cardon = cardon_q;
  assign rgb    = rgb_q;

endmodule

// File: tb/tb_card_grid_renderer.sv
module tb_card_grid_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] HCount = '0;
  logic [9:0] VCount = '0;
  logic       frame_tick = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_idx = '0;
  logic       busy;
  logic [3:0] rom_card;
  logic       rom_face;
  logic [6:0] rom_x;
  logic [6:0] rom_y;
  logic [2:0] rom_pix;
  logic       cardon;
  logic [2:0] rgb;
`ifdef CURSOR_EN
  logic [3:0] cursor_idx = 4'd15;
`endif

  int errors = 0;
  int checks = 0;

  // ROM stand-in: pix = {face,0,1} ^ x[2:0] ^ {y[1:0],0}
  assign rom_pix = {rom_face, 1'b0, 1'b1} ^ rom_x[2:0] ^ {rom_y[1:0], 1'b0};

  always #5 clk = ~clk;

  card_grid_renderer #(
    .COLS(4), .ROWS(4), .IDX_W(4), .CARD_W(83), .CARD_H(83),
    .PITCH_X(100), .PITCH_Y(100), .ORG_X(130), .ORG_Y(70), .FLIP_FRAMES(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .HCount    (HCount),
    .VCount    (VCount),
    .frame_tick(frame_tick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_idx   (cmd_idx),
    .busy      (busy),
    .rom_card  (rom_card),
    .rom_face  (rom_face),
    .rom_x     (rom_x),
    .rom_y     (rom_y),
    .rom_pix   (rom_pix),
`ifdef CURSOR_EN
    .cursor_idx(cursor_idx),
`endif
    .cardon    (cardon),
    .rgb       (rgb)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a pixel, then wait out the 2-cycle pipeline and land on a negedge.
  task automatic scan(input int x, input int y);
    @(negedge clk);
    HCount = 10'(x);
    VCount = 10'(y);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] idx, input logic tk);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_idx    = idx;
    frame_tick = tk;
    @(negedge clk);
    cmd_valid  = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a card pixel on the scan inputs
    HCount = 10'd130;
    VCount = 10'd70;
    repeat (3) @(negedge clk);
    chk("rst_cardon", cardon, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rom_card", rom_card, 0);
    chk("rst_rom_face", rom_face, 0);
    chk("rst_rom_x", rom_x, 0);
    chk("rst_rom_y", rom_y, 0);
    reset = 1'b0;

    // Card 0 corners and gaps
    scan(130, 70);
    chk("c0_cardon", cardon, 1);
    chk("c0_face", rom_face, 0);
    chk("c0_x", rom_x, 0);
    chk("c0_y", rom_y, 0);
    chk("c0_card", rom_card, 0);
    chk("c0_rgb", rgb, 3'b001);
    scan(212, 152);
    chk("c0br_cardon", cardon, 1);
    chk("c0br_x", rom_x, 82);
    chk("c0br_y", rom_y, 82);
    chk("c0br_rgb", rgb, 3'b111);
    scan(213, 70);
    chk("gapx_cardon", cardon, 0);
    chk("gapx_rgb", rgb, 0);
    scan(130, 153);
    chk("gapy_cardon", cardon, 0);
    chk("gapy_rgb", rgb, 0);
    scan(129, 70);
    chk("left_cardon", cardon, 0);
    scan(512, 452);
    chk("c15_cardon", cardon, 1);
    chk("c15_card", rom_card, 15);
    scan(513, 452);
    chk("right_cardon", cardon, 0);
    scan(230, 170);
    chk("c5_card", rom_card, 5);
    chk("c5_x", rom_x, 0);

    // Show card 5 (tick during acceptance must be ignored)
    cmd(2'b00, 4'd5, 1'b1);
    chk("flip_busy", busy, 1);
    chk("flip_ready", cmd_ready, 0);
    ticks(3);
    scan(240, 170);
    chk("m15_lx10_cardon", cardon, 0);
    chk("m15_lx10_rgb", rgb, 0);
    scan(249, 170);
    chk("m15_lx19_cardon", cardon, 1);
    scan(250, 170);
    chk("m15_lx20_cardon", cardon, 1);
    chk("m15_lx20_face", rom_face, 0);
    chk("m15_lx20_rgb", rgb, 3'b101);
    scan(297, 170);
    chk("m15_lx67_cardon", cardon, 1);
    scan(298, 170);
    chk("m15_lx68_cardon", cardon, 0);
    ticks(4);
    scan(270, 170);
    chk("n7_face", rom_face, 0);
    ticks(1);
    scan(270, 170);
    chk("n8_cardon", cardon, 1);
    chk("n8_face", rom_face, 1);
    chk("n8_rgb", rgb, 3'b101);
    chk("n8_busy", busy, 1);
    scan(250, 170);
    chk("n8_lx20_cardon", cardon, 0);
    ticks(7);
    chk("t15_busy", busy, 1);
    ticks(1);
    chk("t16_busy", busy, 0);
    chk("t16_ready", cmd_ready, 1);
    scan(240, 170);
    chk("up_cardon", cardon, 1);
    chk("up_face", rom_face, 1);
    chk("up_rgb", rgb, 3'b111);

    // Match card 5, then no-op commands
    cmd(2'b10, 4'd5, 1'b0);
    chk("match_busy", busy, 0);
    scan(240, 200);
    chk("matched_cardon", cardon, 0);
    chk("matched_rgb", rgb, 0);
    cmd(2'b00, 4'd5, 1'b0);
    chk("matched_show_busy", busy, 0);
    cmd(2'b01, 4'd0, 1'b0);
    chk("hide_down_busy", busy, 0);
    cmd(2'b00, 4'd15, 1'b0);
    chk("c15_flip_busy", busy, 1);
    ticks(16);
    chk("c15_done_busy", busy, 0);
    scan(430, 370);
    chk("c15_face_up", rom_face, 1);
    cmd(2'b00, 4'd15, 1'b0);
    chk("show_up_busy", busy, 0);

    // Clear board
    cmd(2'b11, 4'd0, 1'b0);
    scan(240, 200);
    chk("clr_c5_cardon", cardon, 1);
    chk("clr_c5_face", rom_face, 0);
    chk("clr_c5_card", rom_card, 5);
    chk("clr_c5_rgb", rgb, 3'b111);
    scan(430, 370);
    chk("clr_c15_face", rom_face, 0);

    // Reset in the middle of an animation
    cmd(2'b00, 4'd0, 1'b0);
    ticks(16);
    scan(130, 70);
    chk("c0_up_face", rom_face, 1);
    cmd(2'b00, 4'd5, 1'b0);
    ticks(4);
    chk("mid_busy", busy, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_ready", cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    scan(130, 70);
    chk("post_c0_cardon", cardon, 1);
    chk("post_c0_face", rom_face, 0);
    scan(240, 170);
    chk("post_c5_cardon", cardon, 1);
    chk("post_c5_face", rom_face, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
